// File: rtl/mux_bin.sv
// mux_bin: binary-select multiplexer returning ary[bin] from a WIDTH-entry array.
// Three interchangeable selection structures; an optional output register adds
// one cycle of latency. Out-of-range selects (non power-of-2 WIDTH) return zero.
module mux_bin #(
  parameter type         DAT_T          = logic [7:0],
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned SPLIT          = 4,
  parameter int unsigned IMPLEMENTATION = 0,
  parameter int unsigned REG_OUT        = 0,
  localparam int unsigned WIDTH_LOG     = $clog2(WIDTH),
  localparam int unsigned SPLIT_LOG     = $clog2(SPLIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_LOG-1:0] bin,
  input  DAT_T                 ary [WIDTH-1:0],
  output DAT_T                 dat
);

  // Tree geometry: number of SPLIT-way levels and the padded leaf count.
  localparam int unsigned LEVELS = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
  localparam int unsigned PAD    = SPLIT ** LEVELS;
  localparam int unsigned SEL_W  = LEVELS * SPLIT_LOG;
  localparam bit          POW2   = ((2 ** WIDTH_LOG) == WIDTH);

  DAT_T sel_c;

  // SPLIT-way reduction, LSB digit of the select first. Leaves beyond WIDTH are
  // zero, so an out-of-range select naturally lands on a zero entry. Each level
  // compacts in place: the read index n*SPLIT+sel is never below the write index n.
  function automatic DAT_T tree_pick(input DAT_T a [WIDTH-1:0],
                                     input logic [WIDTH_LOG-1:0] b);
    DAT_T                 node [PAD];
    logic [SEL_W-1:0]     bsel;
    logic [SPLIT_LOG-1:0] sel;
    bsel = SEL_W'(b);
    for (int unsigned i = 0; i < PAD; i++) node[i] = '0;
    for (int unsigned i = 0; i < WIDTH; i++) node[i] = a[i];
    for (int unsigned l = 0; l < LEVELS; l++) begin
      sel = bsel[l*SPLIT_LOG +: SPLIT_LOG];
      for (int unsigned n = 0; n < PAD / (SPLIT ** (l + 1)); n++) begin
        node[n] = node[n*SPLIT + 32'(sel)];
      end
    end
    return node[0];
  endfunction

  generate
    if (IMPLEMENTATION == 0) begin : g_index
      if (POW2) begin : g_full
        // Every select value addresses a real entry.
        always_comb begin
          sel_c = ary[bin];
        end
      end else begin : g_part
        // Guard the index so unused select codes read as zero.
        always_comb begin
          sel_c = '0;
          if (32'(bin) < WIDTH) sel_c = ary[bin];
        end
      end
    end else if (IMPLEMENTATION == 1) begin : g_tree
      // Radix-SPLIT selection tree.
      always_comb begin
        sel_c = tree_pick(ary, bin);
      end
    end else if (IMPLEMENTATION == 2) begin : g_onehot
      logic [WIDTH-1:0] onehot;
      // Decode then AND-OR: unselected entries are masked to zero, so X on them
      // cannot reach the output.
      always_comb begin
        onehot = '0;
        sel_c  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          onehot[i] = (32'(bin) == i);
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
          sel_c = sel_c | (ary[i] & {$bits(DAT_T){onehot[i]}});
        end
      end
    end else begin : g_bad
      $error("mux_bin: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
      always_comb begin
        sel_c = '0;
      end
    end
  endgenerate

  generate
    if (REG_OUT != 0) begin : g_reg
      // Output register, cleared asynchronously by rst.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dat <= '0;
        else     dat <= sel_c;
      end
    end else begin : g_comb
      logic unused_clk_rst;
      // Combinational output; clock and reset are not used in this mode.
      assign unused_clk_rst = clk ^ rst;
      assign dat = sel_c;
    end
  endgenerate

endmodule

// File: tb/tb_mux_bin.sv
// Directed bench for mux_bin: sweeps, tree shapes, non power-of-2 width,
// X isolation, registered latency and asynchronous reset.
module tb_mux_bin;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] b16 = '0;
  logic [3:0] b12 = '0;
  logic [7:0] a16 [15:0];
  logic [7:0] a12 [11:0];
  logic [7:0] d_i0, d_i1, d_i2, d_s2, d_s16, d_n0, d_n1, d_n2, d_reg;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_bin #(.WIDTH(16), .SPLIT(4),  .IMPLEMENTATION(0)) u_i0  (.clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d_i0));
  mux_bin #(.WIDTH(16), .SPLIT(4),  .IMPLEMENTATION(1)) u_i1  (.clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d_i1));
  mux_bin #(.WIDTH(16), .SPLIT(4),  .IMPLEMENTATION(2)) u_i2  (.clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d_i2));
  mux_bin #(.WIDTH(16), .SPLIT(2),  .IMPLEMENTATION(1)) u_s2  (.clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d_s2));
  mux_bin #(.WIDTH(16), .SPLIT(16), .IMPLEMENTATION(1)) u_s16 (.clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d_s16));
  mux_bin #(.WIDTH(12), .SPLIT(4),  .IMPLEMENTATION(0)) u_n0  (.clk(clk), .rst(rst), .bin(b12), .ary(a12), .dat(d_n0));
  mux_bin #(.WIDTH(12), .SPLIT(4),  .IMPLEMENTATION(1)) u_n1  (.clk(clk), .rst(rst), .bin(b12), .ary(a12), .dat(d_n1));
  mux_bin #(.WIDTH(12), .SPLIT(4),  .IMPLEMENTATION(2)) u_n2  (.clk(clk), .rst(rst), .bin(b12), .ary(a12), .dat(d_n2));
  mux_bin #(.WIDTH(16), .SPLIT(4),  .IMPLEMENTATION(0), .REG_OUT(1)) u_reg (.clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d_reg));

  // One comparison: 4-state equality so X on the output counts as a miscompare.
  task automatic check(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) a16[i] = 8'(i);
    for (int i = 0; i < 12; i++) a12[i] = 8'(i);

    // Registered output held at zero while rst is high across an edge.
    @(posedge clk);
    #1 check("reg_rst_hold", 0, d_reg, 8'h00);

    // Full sweep over all 16-entry variants.
    for (int i = 0; i < 16; i++) begin
      b16 = 4'(i);
      #1;
      check("imp0", i, d_i0,  8'(i));
      check("imp1", i, d_i1,  8'(i));
      check("imp2", i, d_i2,  8'(i));
      check("s2",   i, d_s2,  8'(i));
      check("s16",  i, d_s16, 8'(i));
    end

    // Non power-of-2 width: last real entry, then unused select codes.
    b12 = 4'd11; #1;
    check("w12_imp0", 11, d_n0, 8'd11);
    check("w12_imp1", 11, d_n1, 8'd11);
    check("w12_imp2", 11, d_n2, 8'd11);
    b12 = 4'd12; #1;
    check("w12_imp0", 12, d_n0, 8'd0);
    check("w12_imp1", 12, d_n1, 8'd0);
    check("w12_imp2", 12, d_n2, 8'd0);
    b12 = 4'd13; #1;
    check("w12_imp0", 13, d_n0, 8'd0);
    check("w12_imp1", 13, d_n1, 8'd0);
    check("w12_imp2", 13, d_n2, 8'd0);
    b12 = 4'd15; #1;
    check("w12_imp0", 15, d_n0, 8'd0);
    check("w12_imp1", 15, d_n1, 8'd0);
    check("w12_imp2", 15, d_n2, 8'd0);

    // X on an unselected entry must not reach the output.
    a16[5] = 8'hxx;
    b16 = 4'd3; #1;
    check("xiso_imp0", 3, d_i0,  8'd3);
    check("xiso_imp1", 3, d_i1,  8'd3);
    check("xiso_imp2", 3, d_i2,  8'd3);
    check("xiso_s2",   3, d_s2,  8'd3);
    check("xiso_s16",  3, d_s16, 8'd3);
    a16[5] = 8'd5;

    // Registered path: one cycle of latency after reset release.
    @(negedge clk);
    b16 = 4'd7;
    rst = 1'b0;
    #1 check("reg_before_edge", 7, d_reg, 8'h00);
    @(posedge clk);
    #1 check("reg_lat1", 7, d_reg, 8'd7);
    @(negedge clk);
    b16 = 4'd9;
    #1 check("reg_hold", 9, d_reg, 8'd7);
    @(posedge clk);
    #1 check("reg_update", 9, d_reg, 8'd9);

    // Asynchronous reset mid-cycle, held until the first edge after release.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", 0, d_reg, 8'h00);
    @(posedge clk);
    #1 check("rst_held", 0, d_reg, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release", 0, d_reg, 8'h00);
    @(posedge clk);
    #1 check("reg_resume", 9, d_reg, 8'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
